fine_delay_interp: RTL and testbench

- Per-channel fine (sub-sample) delay stage of the receive beamformer.
- Sits directly downstream of the coarse delay unit and consumes its output samples and valid strobe.
- Applies a per-sample fractional delay by 2-tap linear interpolation. The delay for each sample comes from a fraction LUT loaded before the receive window.
- Output feeds the apodization multiplier ahead of the channel summation.

---
 rtl/fine_delay_interp.sv | 147 ++++++++++++++
 tb/tb_fine_delay_interp.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fine_delay_interp.sv
// Fine (sub-sample) delay stage: 2-tap linear interpolation between the current and
// previous accepted sample, with a per-sample fraction taken from a preloaded LUT.
`timescale 1ns/1ps
module fine_delay_interp #(
    parameter int unsigned INPUT_WD  = 14,
    parameter int unsigned FRAC_WD   = 4,
    parameter int unsigned ADDR_WD   = 12,
    parameter int unsigned FD_OUT_WD = 18
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        tx_en,
    input  logic [ADDR_WD-1:0]          lut_wr_addr,
    input  logic [FRAC_WD-1:0]          lut_wr_data,
    input  logic                        lut_we,
    input  logic signed [INPUT_WD-1:0]  fine_din,
    input  logic                        fine_din_valid,
    output logic signed [FD_OUT_WD-1:0] fine_dout,
    output logic                        fine_dout_valid,
    output logic                        fd_busy
);

    localparam int unsigned DEPTH  = 1 << ADDR_WD;
    localparam int unsigned WGT_WD = FRAC_WD + 2;
    localparam logic [ADDR_WD-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                       state_q;
    logic                         fd_busy_q;
    logic [ADDR_WD-1:0]           cnt_q;
    logic signed [INPUT_WD-1:0]   x_prev_q;
    logic signed [INPUT_WD-1:0]   x_q;
    logic signed [INPUT_WD-1:0]   xp_q;
    logic                         v1_q;
    logic                         v2_q;
    logic [FRAC_WD-1:0]           f_q;
    logic signed [FD_OUT_WD-1:0]  a_q;
    logic signed [FD_OUT_WD-1:0]  b_q;
    logic signed [FD_OUT_WD-1:0]  dout_q;
    logic                         dout_valid_q;
    logic [FRAC_WD-1:0]           lut_mem_q [DEPTH];

    logic                         accept_c;
    logic [FRAC_WD:0]             wx_c;
    logic signed [WGT_WD-1:0]     wx_s_c;
    logic signed [WGT_WD-1:0]     wxp_s_c;
    logic signed [FD_OUT_WD-1:0]  a_c;
    logic signed [FD_OUT_WD-1:0]  b_c;

    // Gated on start rather than state so the sample arriving with the IDLE->RUN
    // decode is taken; start low always means "leaving/staying in IDLE".
    assign accept_c = start & fine_din_valid & ~tx_en;

    // Weights are unsigned, zero-extended into signed operands; products fit FD_OUT_WD.
    assign wx_c    = {1'b1, {FRAC_WD{1'b0}}} - {1'b0, f_q};
    assign wx_s_c  = {1'b0, wx_c};
    assign wxp_s_c = {2'b00, f_q};
    assign a_c     = FD_OUT_WD'(x_q)  * FD_OUT_WD'(wx_s_c);
    assign b_c     = FD_OUT_WD'(xp_q) * FD_OUT_WD'(wxp_s_c);

    // Fraction LUT: read-first single-port-per-direction RAM, never reset.
    always_ff @(posedge clk) begin
        if (lut_we) begin
            lut_mem_q[lut_wr_addr] <= lut_wr_data;
        end
        if (accept_c) begin
            f_q <= lut_mem_q[cnt_q];
        end
    end

    // Datapath registers; qualified by the valid pipeline, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            x_q  <= fine_din;
            xp_q <= x_prev_q;
        end
        if (v1_q) begin
            a_q <= a_c;
            b_q <= b_c;
        end
    end

    // Control FSM, sample counter, history and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fd_busy_q    <= 1'b0;
            cnt_q        <= '0;
            x_prev_q     <= '0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= RUN;
                        fd_busy_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (!start) begin
                        state_q   <= IDLE;
                        fd_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    fd_busy_q <= 1'b0;
                end
            endcase

            if (!start) begin
                cnt_q        <= '0;
                x_prev_q     <= '0;
                v1_q         <= 1'b0;
                v2_q         <= 1'b0;
                dout_q       <= '0;
                dout_valid_q <= 1'b0;
            end else begin
                v1_q         <= accept_c;
                v2_q         <= v1_q;
                dout_valid_q <= v2_q;
                if (accept_c) begin
                    x_prev_q <= fine_din;
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + ADDR_WD'(1);
                    end
                end
                if (v2_q) begin
                    dout_q <= a_q + b_q;
                end
            end
        end
    end

    assign fine_dout       = dout_q;
    assign fine_dout_valid = dout_valid_q;
    assign fd_busy         = fd_busy_q;

endmodule

// File: tb/tb_fine_delay_interp.sv
// Directed bench for fine_delay_interp: hand-computed interpolation results per cycle.
`timescale 1ns/1ps
module tb_fine_delay_interp;

    localparam int unsigned INPUT_WD  = 14;
    localparam int unsigned FRAC_WD   = 4;
    localparam int unsigned ADDR_WD   = 12;
    localparam int unsigned FD_OUT_WD = 18;
    localparam int          DEPTH     = 4096;

    logic                        clk;
    logic                        rst_n;
    logic                        start;
    logic                        tx_en;
    logic [ADDR_WD-1:0]          lut_wr_addr;
    logic [FRAC_WD-1:0]          lut_wr_data;
    logic                        lut_we;
    logic signed [INPUT_WD-1:0]  fine_din;
    logic                        fine_din_valid;
    logic signed [FD_OUT_WD-1:0] fine_dout;
    logic                        fine_dout_valid;
    logic                        fd_busy;

    int checks = 0;
    int errors = 0;

    fine_delay_interp #(
        .INPUT_WD (INPUT_WD),
        .FRAC_WD  (FRAC_WD),
        .ADDR_WD  (ADDR_WD),
        .FD_OUT_WD(FD_OUT_WD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .tx_en          (tx_en),
        .lut_wr_addr    (lut_wr_addr),
        .lut_wr_data    (lut_wr_data),
        .lut_we         (lut_we),
        .fine_din       (fine_din),
        .fine_din_valid (fine_din_valid),
        .fine_dout      (fine_dout),
        .fine_dout_valid(fine_dout_valid),
        .fd_busy        (fd_busy)
    );

    initial begin
        clk = 1'b0;
        forever #12.5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input int tx, input int v, input int d);
        start          = (s != 0);
        tx_en          = (tx != 0);
        fine_din_valid = (v != 0);
        fine_din       = INPUT_WD'(d);
        tick();
    endtask

    task automatic lut_write(input int a, input int d);
        lut_we      = 1'b1;
        lut_wr_addr = ADDR_WD'(a);
        lut_wr_data = FRAC_WD'(d);
        tick();
        lut_we      = 1'b0;
    endtask

    // ramp != 0 loads LUT[k] = k mod 16, otherwise every entry = c.
    task automatic lut_fill(input int ramp, input int c);
        for (int k = 0; k < DEPTH; k++) begin
            lut_write(k, (ramp != 0) ? (k % 16) : c);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; tx_en = 1'b0; lut_we = 1'b0;
        lut_wr_addr = '0; lut_wr_data = '0; fine_din = '0; fine_din_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (fine_dout !== '0) begin
            errors++; $display("FAIL reset_dout: got %0d expected 0", fine_dout);
        end
        checks++;
        if (fine_dout_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %0b expected 0", fine_dout_valid);
        end
        checks++;
        if (fd_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %0b expected 0", fd_busy);
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 0);
    endtask

    task automatic test_f0();
        int st[6] = '{1, 1, 1, 1, 1, 0};
        int vi[6] = '{1, 1, 1, 0, 0, 0};
        int di[6] = '{1, 2, 3, 0, 0, 0};
        int ev[6] = '{0, 0, 1, 1, 1, 0};
        int ed[6] = '{0, 0, 16, 32, 48, 0};
        lut_fill(0, 0);
        for (int i = 0; i < 6; i++) begin
            drive(st[i], 0, vi[i], di[i]);
            checks++;
            if (32'(fine_dout_valid) !== ev[i] || fine_dout !== FD_OUT_WD'(ed[i])) begin
                errors++;
                $display("FAIL f0 step %0d: valid=%0b dout=%0d expected valid=%0d dout=%0d",
                         i, fine_dout_valid, fine_dout, ev[i], ed[i]);
            end
            if (i == 0) begin
                checks++;
                if (fd_busy !== 1'b1) begin
                    errors++; $display("FAIL f0_busy: got %0b expected 1", fd_busy);
                end
            end
        end
    endtask

    task automatic test_half();
        int st[6] = '{1, 1, 1, 1, 1, 0};
        int vi[6] = '{1, 1, 0, 0, 0, 0};
        int di[6] = '{100, 200, 0, 0, 0, 0};
        int ev[6] = '{0, 0, 1, 1, 0, 0};
        int ed[6] = '{0, 0, 800, 2400, 2400, 0};
        lut_fill(0, 8);
        for (int i = 0; i < 6; i++) begin
            drive(st[i], 0, vi[i], di[i]);
            checks++;
            if (32'(fine_dout_valid) !== ev[i] || fine_dout !== FD_OUT_WD'(ed[i])) begin
                errors++;
                $display("FAIL half step %0d: valid=%0b dout=%0d expected valid=%0d dout=%0d",
                         i, fine_dout_valid, fine_dout, ev[i], ed[i]);
            end
        end
    endtask

    task automatic test_extremes();
        int st[6] = '{1, 1, 1, 1, 1, 0};
        int vi[6] = '{1, 1, 0, 0, 0, 0};
        int di[6] = '{-8192, 8191, 0, 0, 0, 0};
        int ev[6] = '{0, 0, 1, 1, 0, 0};
        int ed[6] = '{0, 0, -131072, -114689, -114689, 0};
        lut_write(0, 0);
        lut_write(1, 15);
        for (int i = 0; i < 6; i++) begin
            drive(st[i], 0, vi[i], di[i]);
            checks++;
            if (32'(fine_dout_valid) !== ev[i] || fine_dout !== FD_OUT_WD'(ed[i])) begin
                errors++;
                $display("FAIL extremes step %0d: valid=%0b dout=%0d expected valid=%0d dout=%0d",
                         i, fine_dout_valid, fine_dout, ev[i], ed[i]);
            end
        end
    endtask

    task automatic test_tx_gap();
        int tx[12] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        int vi[12] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        int di[12] = '{10, 20, 999, 999, 30, 40, 50, 60, 0, 0, 0, 0};
        int ev[12] = '{0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0};
        int ed[12] = '{0, 0, 160, 310, 310, 310, 460, 610, 760, 910, 910, 0};
        lut_fill(1, 0);
        for (int i = 0; i < 12; i++) begin
            drive((i < 11) ? 1 : 0, tx[i], vi[i], di[i]);
            checks++;
            if (32'(fine_dout_valid) !== ev[i] || fine_dout !== FD_OUT_WD'(ed[i])) begin
                errors++;
                $display("FAIL tx_gap step %0d: valid=%0b dout=%0d expected valid=%0d dout=%0d",
                         i, fine_dout_valid, fine_dout, ev[i], ed[i]);
            end
        end
    endtask

    task automatic test_restart();
        int st[10] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 0};
        int vi[10] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        int di[10] = '{10, 20, 30, 77, 50, 60, 0, 0, 0, 0};
        int ev[10] = '{0, 0, 1, 0, 0, 0, 1, 1, 0, 0};
        int ed[10] = '{0, 0, 160, 0, 0, 0, 800, 950, 950, 0};
        int eb[10] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 0};
        for (int i = 0; i < 10; i++) begin
            drive(st[i], 0, vi[i], di[i]);
            checks++;
            if (32'(fine_dout_valid) !== ev[i] || fine_dout !== FD_OUT_WD'(ed[i])) begin
                errors++;
                $display("FAIL restart step %0d: valid=%0b dout=%0d expected valid=%0d dout=%0d",
                         i, fine_dout_valid, fine_dout, ev[i], ed[i]);
            end
            checks++;
            if (32'(fd_busy) !== eb[i]) begin
                errors++;
                $display("FAIL restart_busy step %0d: got %0b expected %0d", i, fd_busy, eb[i]);
            end
        end
    endtask

    task automatic test_saturate_and_reset();
        int rs[10] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
        int vi[10] = '{1, 1, 1, 1, 0, 0, 0, 1, 0, 0};
        int di[10] = '{5, 6, 7, 8, 0, 0, 0, 9, 0, 0};
        int ev[10] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
        int ed[10] = '{0, 0, 80, 0, 0, 0, 0, 0, 0, 144};
        int eb[10] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
        int n;
        int f;
        lut_fill(1, 0);
        lut_write(4095, 7);
        // Sample n (1-based) = n gives 16n - f, f = LUT[min(n-1, 4095)].
        for (int i = 0; i < 4102; i++) begin
            drive(1, 0, (i < 4100) ? 1 : 0, i + 1);
            if (i >= 2) begin
                n = i - 1;
                f = (n - 1 < 4095) ? ((n - 1) % 16) : 7;
                checks++;
                if (fine_dout_valid !== 1'b1 || fine_dout !== FD_OUT_WD'(16 * n - f)) begin
                    errors++;
                    $display("FAIL saturate sample %0d: valid=%0b dout=%0d expected valid=1 dout=%0d",
                             n, fine_dout_valid, fine_dout, 16 * n - f);
                end
            end
        end
        drive(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            rst_n = (rs[i] != 0);
            drive(1, 0, vi[i], di[i]);
            checks++;
            if (32'(fine_dout_valid) !== ev[i] || fine_dout !== FD_OUT_WD'(ed[i])) begin
                errors++;
                $display("FAIL midreset step %0d: valid=%0b dout=%0d expected valid=%0d dout=%0d",
                         i, fine_dout_valid, fine_dout, ev[i], ed[i]);
            end
            checks++;
            if (32'(fd_busy) !== eb[i]) begin
                errors++;
                $display("FAIL midreset_busy step %0d: got %0b expected %0d", i, fd_busy, eb[i]);
            end
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_f0();
        test_half();
        test_extremes();
        test_tx_gap();
        test_restart();
        test_saturate_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
